// File: rtl/dir_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : dir_button_debounce
//  Description : Input stage for the 5-way direction display decoder.
//                Synchronises and debounces five raw pushbuttons, then
//                arbitrates the stable levels into a one-hot-or-zero
//                direction vector {l,c,d,u,r}, a one-cycle press pulse and
//                a 3-bit direction code (0 none, 1 l, 2 c, 3 d, 4 u, 5 r).
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int LATCH           = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_l,
    input  logic       btn_c,
    input  logic       btn_d,
    input  logic       btn_u,
    input  logic       btn_r,
    output logic       l,
    output logic       c,
    output logic       d,
    output logic       u,
    output logic       r,
    output logic       press,
    output logic [2:0] dir_code
);

    // Counter value on which a persisting new level is accepted.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Arbiter states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    // Bit order everywhere: [4]=l, [3]=c, [2]=d, [1]=u, [0]=r.
    logic [4:0] w_raw;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_stable;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_held;
    logic [4:0] w_held_nxt;
    logic [4:0] r_dir;
    logic [4:0] w_dir_nxt;
    logic       r_press;
    logic       w_press_nxt;
    logic [2:0] r_code;
    logic [2:0] w_code_nxt;
    logic [4:0] w_rest;
    logic       w_onehot;
    logic       w_none;

    assign w_raw = {btn_l, btn_c, btn_d, btn_u, btn_r};

    // Two-flop synchroniser; the raw buttons are asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 5'b0;
            r_sync2 <= 5'b0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // One debouncer per button: a new synchronised level must be seen on
    // DEBOUNCE_CYCLES consecutive edges before it replaces the stable level.
    // Any reversion in between clears the count.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_deb
            logic [CNT_W-1:0] r_cnt;
            logic             r_stable;

            // Count consecutive disagreeing samples; accept on the last one.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync2[gi] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_stable <= r_sync2[gi];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_stable[gi] = r_stable;
        end
    endgenerate

    // Classification of the stable vector.
    assign w_none   = (w_stable == 5'b0);
    assign w_onehot = !w_none && ((w_stable & (w_stable - 5'd1)) == 5'b0);

    // What the outputs show when no direction is actively held.
    assign w_rest   = (LATCH != 0) ? r_held : 5'b0;

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_held  <= 5'b0;
            r_dir   <= 5'b0;
            r_press <= 1'b0;
            r_code  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_held  <= w_held_nxt;
            r_dir   <= w_dir_nxt;
            r_press <= w_press_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // Next-state and next-output decision. A new direction is only taken
    // from IDLE, so press can never fire twice in a row and multi-button
    // combinations always have to be fully released first.
    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held;
        w_dir_nxt   = r_dir;
        w_press_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_onehot) begin
                    w_state_nxt = ST_HELD;
                    w_held_nxt  = w_stable;
                    w_dir_nxt   = w_stable;
                    w_press_nxt = 1'b1;
                end else if (!w_none) begin
                    w_state_nxt = ST_WAIT_REL;
                end else begin
                    w_dir_nxt = w_rest;
                end
            end
            ST_HELD: begin
                if (w_stable == r_held) begin
                    w_dir_nxt = r_held;
                end else if (w_none) begin
                    w_state_nxt = ST_IDLE;
                    w_dir_nxt   = w_rest;
                end else begin
                    w_state_nxt = ST_WAIT_REL;
                    w_dir_nxt   = w_rest;
                end
            end
            ST_WAIT_REL: begin
                w_dir_nxt = w_rest;
                if (w_none) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_dir_nxt   = 5'b0;
            end
        endcase
    end

    // Direction code derived from the next direction vector so that the
    // registered code always matches the registered vector.
    always_comb begin
        w_code_nxt = 3'd0;
        case (w_dir_nxt)
            5'b10000: w_code_nxt = 3'd1;
            5'b01000: w_code_nxt = 3'd2;
            5'b00100: w_code_nxt = 3'd3;
            5'b00010: w_code_nxt = 3'd4;
            5'b00001: w_code_nxt = 3'd5;
            default:  w_code_nxt = 3'd0;
        endcase
    end

    assign {l, c, d, u, r} = r_dir;
    assign press           = r_press;
    assign dir_code        = r_code;

endmodule
`default_nettype wire
